// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command front end for the ALU datapath with multi-cycle MULTU and HI/LO ownership
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = $clog2(MUL_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_funct,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic [5:0]  dp_signal,
    output logic        dp_mul_reset,
    input  logic [31:0] dp_result,
    input  logic [63:0] dp_prod,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        hilo_valid,
    output logic        busy
);

    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALU,
        S_MUL,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [5:0]       funct;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [CNT_W-1:0] cnt;
    logic             mul_first;
    logic             mul_done;
    logic             accept;

    function automatic logic is_alu(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SRL: is_alu = 1'b1;
            default:                                 is_alu = 1'b0;
        endcase
    endfunction

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        dp_signal    = 6'd0;
        dp_mul_reset = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        mul_done     = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (is_alu(cmd_funct)) begin
                        state_next = S_ALU;
                    end else if (cmd_funct == F_MULTU) begin
                        state_next = S_MUL;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_ALU: begin
                dp_signal  = funct;
                state_next = S_RESP;
            end
            S_MUL: begin
                // The first MUL cycle only clears the multiplier; counting starts after it.
                dp_signal    = F_MULTU;
                dp_mul_reset = mul_first;
                if (!mul_first && cnt == CNT_LAST) begin
                    mul_done   = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dp_a       <= 32'd0;
            dp_b       <= 32'd0;
            funct      <= 6'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            hilo_valid <= 1'b0;
            cnt        <= '0;
            mul_first  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dp_a  <= cmd_a;
                        dp_b  <= cmd_b;
                        funct <= cmd_funct;
                        if (cmd_funct == F_MULTU) begin
                            cnt       <= '0;
                            mul_first <= 1'b1;
                        end else if (cmd_funct == F_MFHI) begin
                            rsp_data <= hi;
                        end else if (cmd_funct == F_MFLO) begin
                            rsp_data <= lo;
                        end else if (!is_alu(cmd_funct)) begin
                            rsp_data <= 32'd0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_ALU: begin
                    rsp_data <= dp_result;
                end
                S_MUL: begin
                    mul_first <= 1'b0;
                    if (mul_done) begin
                        hi         <= dp_prod[63:32];
                        lo         <= dp_prod[31:0];
                        hilo_valid <= 1'b1;
                        rsp_data   <= 32'd0;
                    end else if (!mul_first) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with ALU and multiplier models
module tb_alu_op_sequencer;

    localparam int MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_funct;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic [5:0]  dp_signal;
    logic        dp_mul_reset;
    logic [31:0] dp_result;
    logic [63:0] dp_prod;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        hilo_valid;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int mcount = 1000;
    logic [5:0] last_sig1;
    int last_mr;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    alu_op_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_signal(dp_signal), .dp_mul_reset(dp_mul_reset),
        .dp_result(dp_result), .dp_prod(dp_prod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .hilo_valid(hilo_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (dp_signal)
            6'd32:   dp_result = dp_a + dp_b;
            6'd34:   dp_result = dp_a - dp_b;
            6'd36:   dp_result = dp_a & dp_b;
            6'd37:   dp_result = dp_a | dp_b;
            6'd42:   dp_result = ($signed(dp_a) < $signed(dp_b)) ? 32'd1 : 32'd0;
            6'd2:    dp_result = dp_a >> dp_b[4:0];
            default: dp_result = 32'd0;
        endcase
    end

    // Product is garbage until MUL_CYCLES cycles after the clear pulse.
    always @(posedge clk) begin
        if (dp_mul_reset) mcount <= 0;
        else if (mcount < 1000) mcount <= mcount + 1;
    end

    always_comb begin
        if (mcount >= MUL_CYCLES - 1 && mcount < 1000) dp_prod = {32'd0, dp_a} * {32'd0, dp_b};
        else dp_prod = 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=0x%0h required=none", rsp_data);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic send(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ed, input logic ee, input int lat);
        int n;
        int mr;
        int rdy;
        logic [5:0] s1;
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_funct = f;
        cmd_a     = a;
        cmd_b     = b;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout actual=0 required=1", nm);
            cmd_valid = 1'b0;
            return;
        end
        e.err  = ee;
        e.data = ed;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0; mr = 0; rdy = 0; s1 = 6'd0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) s1 = dp_signal;
            if (dp_mul_reset) mr++;
            if (cmd_ready) rdy++;
        end while (!rsp_valid && n < 200);
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_ready_low"}, 64'(rdy), 64'd0);
        last_sig1 = s1;
        last_mr   = mr;
        n = 0;
        while (!(rsp_valid && rsp_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rsp_t e;
        reset = 1'b1; cmd_valid = 1'b0; cmd_funct = 6'd0; cmd_a = 32'd0; cmd_b = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dp_signal", 64'(dp_signal), 64'd0);
        chk("rst_mul_reset", 64'(dp_mul_reset), 64'd0);
        chk("rst_hilo_valid", 64'(hilo_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_dp_a", 64'(dp_a), 64'd0);
        @(posedge clk);
        #1;

        send("mflo_rst", 6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        chk("mflo_rst_hilo", 64'(hilo_valid), 64'd0);
        send("add", 6'd32, 32'd5, 32'd3, 32'd8, 1'b0, 2);
        chk("add_dp_signal", 64'(last_sig1), 64'd32);
        send("sub", 6'd34, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 2);
        send("slt", 6'd42, 32'd3, 32'd5, 32'd1, 1'b0, 2);
        send("srl", 6'd2, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 2);
        send("multu", 6'd25, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, MUL_CYCLES + 2);
        chk("multu_dp_signal", 64'(last_sig1), 64'd25);
        chk("multu_mul_reset_pulses", 64'(last_mr), 64'd1);
        chk("multu_hilo_valid", 64'(hilo_valid), 64'd1);
        send("mfhi", 6'd16, 32'd0, 32'd0, 32'd1, 1'b0, 1);
        send("mflo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1);

        // Backpressure: response stalls 5 cycles while the next command waits.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_funct = 6'd32; cmd_a = 32'd1; cmd_b = 32'd1;
        @(negedge clk);
        chk("bp_accept", 64'(cmd_ready), 64'd1);
        e.err = 1'b0; e.data = 32'd2;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_funct = 6'd37; cmd_a = 32'd4; cmd_b = 32'd1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", 64'(rsp_data), 64'd2);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_turnaround", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_second_accept", 64'(cmd_ready), 64'd1);
        e.err = 1'b0; e.data = 32'd5;
        sb_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(rsp_valid && rsp_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_rsp", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;

        send("illegal", 6'd63, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        send("mfhi_after_ill", 6'd16, 32'd0, 32'd0, 32'd1, 1'b0, 1);
        send("mflo_after_ill", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1);
        send("add_err_clear", 6'd36, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 2);

        send("multu23", 6'd25, 32'd2, 32'd3, 32'd0, 1'b0, MUL_CYCLES + 2);
        send("mflo23", 6'd18, 32'd0, 32'd0, 32'd6, 1'b0, 1);

        // Reset lands mid-multiply; HI/LO must never see 42.
        cmd_valid = 1'b1; cmd_funct = 6'd25; cmd_a = 32'd7; cmd_b = 32'd6;
        @(negedge clk);
        chk("abort_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_inflight_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_dp_signal", 64'(dp_signal), 64'd0);
        chk("abort_hilo_valid", 64'(hilo_valid), 64'd0);
        chk("abort_dp_a", 64'(dp_a), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        send("mflo_abort", 6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        send("mfhi_abort", 6'd16, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        chk("abort_hilo_after", 64'(hilo_valid), 64'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
